// File: rtl/data_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_if
//
// Purpose:
//   Bundles the two requester channels and the single-port data RAM port seen
//   by data_mem_arbiter.
//
// Signals (per requester n = 0, 1):
//   reqn_valid  request present
//   reqn_ready  request accepted this cycle
//   reqn_we     1 = store, 0 = load
//   reqn_addr   byte address
//   reqn_wdata  store data, lane-aligned
//   reqn_be     byte enables, bit i covers wdata[8i+7:8i]
//   rspn_valid  one-cycle response pulse
//   rspn_rdata  word read (pre-write contents for stores)
//   rspn_err    error flag (misaligned access when alignment checking is built in)
// RAM port:
//   ram_we, ram_addr, ram_wd  driven by the arbiter
//   ram_rd                    combinational read data from the RAM
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (both requesters plus the RAM)
// -----------------------------------------------------------------------------
interface data_mem_arbiter_if #(
  parameter int WIDTH = 32
);

  logic             req0_valid;
  logic             req0_ready;
  logic             req0_we;
  logic [WIDTH-1:0] req0_addr;
  logic [WIDTH-1:0] req0_wdata;
  logic [3:0]       req0_be;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_rdata;
  logic             rsp0_err;

  logic             req1_valid;
  logic             req1_ready;
  logic             req1_we;
  logic [WIDTH-1:0] req1_addr;
  logic [WIDTH-1:0] req1_wdata;
  logic [3:0]       req1_be;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_rdata;
  logic             rsp1_err;

  logic             ram_we;
  logic [WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0] ram_wd;
  logic [WIDTH-1:0] ram_rd;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata, req0_be,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_valid, req1_we, req1_addr, req1_wdata, req1_be,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output ram_we, ram_addr, ram_wd,
    input  ram_rd
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata, req0_be,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_valid, req1_we, req1_addr, req1_wdata, req1_be,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  ram_we, ram_addr, ram_wd,
    output ram_rd
  );

endinterface

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Purpose:
//   Arbitrates two requesters (0 = CPU load/store path, 1 = debug/DMA loader)
//   round-robin onto a single-port data RAM with combinational read and
//   synchronous whole-word write. Partial byte-enable stores are turned into a
//   read-modify-write: the old word is read in ACCESS, merged, and written back
//   in WRITE.
//
// Parameters:
//   WIDTH       data/address width, 32 only (4 byte lanes)
//   RESET_PRIO  requester that wins the first tie after reset (0 or 1)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    data_mem_arbiter_if.slave - both requester channels and the RAM port
//
// Optional build macro:
//   DATA_ARB_ALIGN_CHECK_EN - when defined, misaligned requests are answered
//   immediately with rsp_err=1 and rsp_rdata=0 without touching the RAM. When
//   undefined, addr[1:0] is masked and rsp_err is tied to 0.
//
// Timing (accept in cycle T):
//   load, full or empty store  -> response in T+2
//   partial store              -> response in T+3
//   misaligned (check enabled) -> response in T+1
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int RESET_PRIO = 0
) (
  input logic               clk,
  input logic               rst_n,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  // Requester that holds priority on the next tie.
  logic             prio_q;

  // Transaction latched at accept.
  logic             we_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [3:0]       be_q;
  logic             owner_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] merge_q;

  // Arbitration and selected request.
  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic             sel_we;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic [3:0]       sel_be;
  logic             misalign;

  // FSM outputs.
  logic             ram_we_c;
  logic [WIDTH-1:0] ram_wd_c;
  logic             rsp0_vld_c;
  logic             rsp1_vld_c;

  // Old word with the enabled lanes replaced by store data.
  function automatic logic [WIDTH-1:0] merge_lanes(
    input logic [3:0]       be,
    input logic [WIDTH-1:0] wd,
    input logic [WIDTH-1:0] rd
  );
    logic [WIDTH-1:0] m;
    m = rd;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
    end
    return m;
  endfunction

  // Grant logic. Ready is combinational from valid and only offered in IDLE;
  // it is held low while reset is asserted so every output reads 0 in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
    accept    = gnt0 | gnt1;
    sel_we    = gnt1 ? bus.req1_we    : bus.req0_we;
    sel_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
    sel_be    = gnt1 ? bus.req1_be    : bus.req0_be;
  end

`ifdef DATA_ARB_ALIGN_CHECK_EN
  // A store fits if its byte enables, shifted up by the address offset, stay
  // inside the word; a load needs an offset of zero.
  logic [7:0] be_span;
  logic       err_q;

  always_comb begin
    be_span = {4'b0000, sel_be} << sel_addr[1:0];
    if (sel_we) misalign = |be_span[7:4];
    else        misalign = (sel_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= misalign;
  end

  assign bus.rsp0_err = rsp0_vld_c & err_q;
  assign bus.rsp1_err = rsp1_vld_c & err_q;
`else
  // Offset bits are simply masked in this build.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^sel_addr[1:0];
  assign misalign        = 1'b0;
  assign bus.rsp0_err    = 1'b0;
  assign bus.rsp1_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Transaction registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q  <= (RESET_PRIO != 0);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      owner_q <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= sel_we;
        addr_q  <= {sel_addr[WIDTH-1:2], 2'b00};
        wdata_q <= sel_wdata;
        be_q    <= sel_be;
        owner_q <= gnt1;
        // Cleared so a request answered without RAM access returns 0.
        rdata_q <= '0;
        // Priority passes to the requester that was not just granted.
        prio_q  <= gnt0;
      end
      if (state_q == ACCESS) begin
        rdata_q <= bus.ram_rd;
        merge_q <= merge_lanes(be_q, wdata_q, bus.ram_rd);
      end
    end
  end

  // Next state and per-state outputs.
  always_comb begin
    state_d    = state_q;
    ram_we_c   = 1'b0;
    ram_wd_c   = '0;
    rsp0_vld_c = 1'b0;
    rsp1_vld_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = misalign ? RESP : ACCESS;
      end
      ACCESS: begin
        state_d = RESP;
        if (we_q) begin
          if (be_q == 4'b1111) begin
            ram_we_c = 1'b1;
            ram_wd_c = wdata_q;
          end else if (be_q != 4'b0000) begin
            // Partial store: write the merged word next cycle.
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        ram_we_c = 1'b1;
        ram_wd_c = merge_q;
        state_d  = RESP;
      end
      RESP: begin
        rsp0_vld_c = ~owner_q;
        rsp1_vld_c = owner_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // ram_addr follows the latched address, so it holds between transactions.
  assign bus.ram_we   = ram_we_c;
  assign bus.ram_addr = addr_q;
  assign bus.ram_wd   = ram_wd_c;

  assign bus.rsp0_valid = rsp0_vld_c;
  assign bus.rsp1_valid = rsp1_vld_c;
  assign bus.rsp0_rdata = rsp0_vld_c ? rdata_q : '0;
  assign bus.rsp1_rdata = rsp1_vld_c ? rdata_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Directed bench for data_mem_arbiter with a 16-word RAM model (indexed by
// ram_addr[5:2]). Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

  logic clk;
  logic rst_n;
  logic mem_init;

  data_mem_arbiter_if #(.WIDTH(32)) bus ();

  data_mem_arbiter #(
    .WIDTH      (32),
    .RESET_PRIO (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:15];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  int          w0;
  logic [3:0]  e;

  // Round-robin table, bits {req0_ready, req1_ready, rsp0_valid, rsp1_valid}.
  localparam logic [3:0] RR_EXP [0:11] = '{
    4'b1000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0001,
    4'b1000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0001
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, synchronous write.
  assign bus.ram_rd = mem[bus.ram_addr[5:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hDEADBEEF;
    end else if (bus.ram_we === 1'b1) begin
      mem[bus.ram_addr[5:2]] <= bus.ram_wd;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a;
    bus.req0_wdata = wd; bus.req0_be = be;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a;
    bus.req1_wdata = wd; bus.req1_be = be;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    mem_init = 1'b1;
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2 rst_n = 1'b0;
    // Valid requests during reset must not be offered ready.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chkb("rst_ready0", bus.req0_ready, 1'b0);
    chkb("rst_ready1", bus.req1_ready, 1'b0);
    chkb("rst_ram_we", bus.ram_we, 1'b0);
    chk ("rst_ram_addr", bus.ram_addr, 32'h0);
    chk ("rst_ram_wd", bus.ram_wd, 32'h0);
    chkb("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    chkb("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
    chk ("rst_rsp0_rdata", bus.rsp0_rdata, 32'h0);
    chkb("rst_rsp0_err", bus.rsp0_err, 1'b0);
    chkb("rst_rsp1_err", bus.rsp1_err, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    mem_init = 1'b0;
    @(negedge clk);

    // Load by requester 0.
    w0 = we_cnt;
    drive0(1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'h0);
    #1;
    chkb("ld_ready0", bus.req0_ready, 1'b1);
    chkb("ld_ready1", bus.req1_ready, 1'b0);
    @(negedge clk);
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chkb("ld_t1_rsp0", bus.rsp0_valid, 1'b0);
    chk ("ld_t1_addr", bus.ram_addr, 32'hBFC00010);
    @(negedge clk);
    #1;
    chkb("ld_t2_rsp0", bus.rsp0_valid, 1'b1);
    chk ("ld_t2_rdata", bus.rsp0_rdata, 32'hDEADBEEF);
    chkb("ld_t2_err", bus.rsp0_err, 1'b0);
    chkb("ld_t2_rsp1", bus.rsp1_valid, 1'b0);
    @(negedge clk);
    #1;
    chkb("ld_t3_rsp0", bus.rsp0_valid, 1'b0);
    chk ("ld_we_cnt", 32'(we_cnt - w0), 32'd0);
    chk ("ld_addr_hold", bus.ram_addr, 32'hBFC00010);

    // Full-word store by requester 1.
    w0 = we_cnt;
    drive1(1'b1, 1'b1, 32'hBFC00020, 32'h12345678, 4'hF);
    #1;
    chkb("st_ready1", bus.req1_ready, 1'b1);
    chkb("st_ready0", bus.req0_ready, 1'b0);
    @(negedge clk);
    drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chkb("st_t1_we", bus.ram_we, 1'b1);
    chk ("st_t1_wd", bus.ram_wd, 32'h12345678);
    chk ("st_t1_addr", bus.ram_addr, 32'hBFC00020);
    @(negedge clk);
    #1;
    chkb("st_t2_we", bus.ram_we, 1'b0);
    chkb("st_t2_rsp1", bus.rsp1_valid, 1'b1);
    chk ("st_t2_rdata", bus.rsp1_rdata, 32'h0);
    chkb("st_t2_rsp0", bus.rsp0_valid, 1'b0);
    chk ("st_we_cnt", 32'(we_cnt - w0), 32'd1);
    chk ("st_mem", mem[8], 32'h12345678);
    @(negedge clk);

    // Read the stored word back.
    drive0(1'b1, 1'b0, 32'hBFC00020, 32'h0, 4'h0);
    #1;
    chkb("rb_ready0", bus.req0_ready, 1'b1);
    @(negedge clk);
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    #1;
    chkb("rb_rsp0", bus.rsp0_valid, 1'b1);
    chk ("rb_rdata", bus.rsp0_rdata, 32'h12345678);
    @(negedge clk);

    // Byte store (read-modify-write) by requester 0.
    w0 = we_cnt;
    drive0(1'b1, 1'b1, 32'hBFC00020, 32'h00AB0000, 4'b0100);
    #1;
    chkb("sb_ready0", bus.req0_ready, 1'b1);
    @(negedge clk);
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chkb("sb_t1_we", bus.ram_we, 1'b0);
    @(negedge clk);
    #1;
    chkb("sb_t2_we", bus.ram_we, 1'b1);
    chk ("sb_t2_wd", bus.ram_wd, 32'h12AB5678);
    chkb("sb_t2_rsp0", bus.rsp0_valid, 1'b0);
    @(negedge clk);
    #1;
    chkb("sb_t3_rsp0", bus.rsp0_valid, 1'b1);
    chk ("sb_t3_rdata", bus.rsp0_rdata, 32'h12345678);
    chkb("sb_t3_we", bus.ram_we, 1'b0);
    chk ("sb_we_cnt", 32'(we_cnt - w0), 32'd1);
    chk ("sb_mem", mem[8], 32'h12AB5678);
    @(negedge clk);

    // Empty-enable store: responds with old data, no write.
    w0 = we_cnt;
    drive1(1'b1, 1'b1, 32'hBFC00010, 32'hFFFFFFFF, 4'b0000);
    #1;
    chkb("es_ready1", bus.req1_ready, 1'b1);
    @(negedge clk);
    drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chkb("es_t1_we", bus.ram_we, 1'b0);
    @(negedge clk);
    #1;
    chkb("es_t2_rsp1", bus.rsp1_valid, 1'b1);
    chk ("es_t2_rdata", bus.rsp1_rdata, 32'hDEADBEEF);
    chk ("es_we_cnt", 32'(we_cnt - w0), 32'd0);
    @(negedge clk);

    // Reset during the WRITE cycle of a partial store.
    drive1(1'b1, 1'b1, 32'hBFC00010, 32'h000000AA, 4'b0001);
    #1;
    chkb("rm_ready1", bus.req1_ready, 1'b1);
    @(negedge clk);
    drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    #1;
    chkb("rm_write_we", bus.ram_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chkb("rm_we_drop", bus.ram_we, 1'b0);
    chkb("rm_rsp1", bus.rsp1_valid, 1'b0);
    @(negedge clk);
    #1;
    chkb("rm_rsp1_after", bus.rsp1_valid, 1'b0);
    chkb("rm_rsp0_after", bus.rsp0_valid, 1'b0);
    chk ("rm_addr", bus.ram_addr, 32'h0);
    chk ("rm_mem", mem[4], 32'hDEADBEEF);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention: both requesters hold loads valid; first tie goes to 0.
    drive0(1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'h0);
    drive1(1'b1, 1'b0, 32'hBFC00020, 32'h0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      #1;
      e = RR_EXP[i];
      chk($sformatf("rr_c%0d", i),
          {28'h0, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid},
          {28'h0, e});
      chk($sformatf("rr_rd0_c%0d", i), bus.rsp0_rdata, e[1] ? 32'hDEADBEEF : 32'h0);
      chk($sformatf("rr_rd1_c%0d", i), bus.rsp1_rdata, e[0] ? 32'h12AB5678 : 32'h0);
      @(negedge clk);
    end
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chkb("rr_idle_ready0", bus.req0_ready, 1'b0);
    chkb("rr_idle_ready1", bus.req1_ready, 1'b0);
    @(negedge clk);

    // Misaligned load.
    w0 = we_cnt;
    drive0(1'b1, 1'b0, 32'hBFC00012, 32'h0, 4'h0);
    #1;
    chkb("ma_ready0", bus.req0_ready, 1'b1);
    @(negedge clk);
    drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
`ifdef DATA_ARB_ALIGN_CHECK_EN
    chkb("ma_t1_rsp0", bus.rsp0_valid, 1'b1);
    chkb("ma_t1_err", bus.rsp0_err, 1'b1);
    chk ("ma_t1_rdata", bus.rsp0_rdata, 32'h0);
    chkb("ma_t1_we", bus.ram_we, 1'b0);
    @(negedge clk);
    #1;
    chkb("ma_t2_rsp0", bus.rsp0_valid, 1'b0);
`else
    chkb("ma_t1_rsp0", bus.rsp0_valid, 1'b0);
    chk ("ma_t1_addr", bus.ram_addr, 32'hBFC00010);
    @(negedge clk);
    #1;
    chkb("ma_t2_rsp0", bus.rsp0_valid, 1'b1);
    chk ("ma_t2_rdata", bus.rsp0_rdata, 32'hDEADBEEF);
    chkb("ma_t2_err", bus.rsp0_err, 1'b0);
`endif
    chk("ma_we_cnt", 32'(we_cnt - w0), 32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Sits between two requesters and the single-port data RAM.
- Requester 0 is the CPU load/store path; requester 1 is the debug/DMA loader.
- Arbitrates round-robin and sequences each access onto the RAM's word-wide port: combinational read, synchronous write.
- Byte-enable stores (SB/SH) become a read-modify-write, because the RAM only writes whole words.

Parameters:
- WIDTH, 32, data/address width; the block supports 32 only (4 byte lanes).
- RESET_PRIO, 0, requester that wins the first tie after reset (0 or 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_we  in  1  1 = store, 0 = load.
- req0_addr  in  WIDTH  byte address.
- req0_wdata  in  WIDTH  store data, lane-aligned.
- req0_be  in  4  byte enables; bit i covers wdata[8i+7:8i].
- rsp0_valid  out  1  one-cycle response pulse.
- rsp0_rdata  out  WIDTH  word read (pre-write contents for stores).
- rsp0_err  out  1  error flag; see Optional Feature.
- req1_*/rsp1_*  same set of ports as requester 0, for requester 1.
- ram_we  out  1  RAM write enable.
- ram_addr  out  WIDTH  RAM byte address, word-aligned.
- ram_wd  out  WIDTH  RAM write data.
- ram_rd  in  WIDTH  RAM combinational read data.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE and the RR pointer to RESET_PRIO.
  - Latched addr/wdata/be/owner clear to 0.
  - All outputs are 0: ram_we, ram_addr, ram_wd, req*_ready, rsp*_valid, rsp*_rdata, rsp*_err.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready is combinational and goes to at most one requester.
  - One valid: that requester wins.
  - Both valid: the requester other than last-granted wins; RR pointer updates on grant.
  - On accept: latch we, addr with [1:0] forced to 0, wdata, be and owner. Go to ACCESS.
  - req_ready is never asserted outside IDLE.
- ACCESS: ram_addr = latched addr; capture ram_rd into rdata_q.
  - Load: ram_we=0 → RESP.
  - Store with be=4'b1111: ram_we=1, ram_wd=wdata → RESP.
  - Store with be=4'b0000: no write, ram_we=0 → RESP (no-op, still responds).
  - Other partial be: ram_we=0; build merge = be lanes from wdata, other lanes from ram_rd; register it → WRITE.
- WRITE: ram_we=1, ram_wd=merge register, same ram_addr → RESP.
- RESP: owner's rsp_valid=1 for exactly one cycle; rsp_rdata=rdata_q → IDLE. The next grant can happen in the following cycle.
- Latency, with accept in cycle T:
  - Load or full/empty store: rsp_valid in T+2.
  - Partial store: rsp_valid in T+3.
  - Back-to-back loads: one per 3 cycles.
- ram_we is asserted in at most one cycle per transaction.
- ram_addr holds its value between transactions.
- Requester inputs are only sampled at accept; changes after accept are ignored.
- Reset mid-operation:
  - The pending transaction is dropped and no response is issued.
  - ram_we falls immediately.
  - If reset asserts in the same cycle as a WRITE edge, the RAM write is not guaranteed.
- rsp*_valid is 0 in every state except RESP, and only for the owner.

Optional Feature:
- Macro: DATA_ARB_ALIGN_CHECK_EN.
- Defined:
  - A load with addr[1:0]≠0 is misaligned.
  - A store is misaligned if addr[1:0]≠0 and the be pattern does not fit within the word from that offset (e.g. be=1111 at offset 2).
  - A misaligned request is accepted, skips ACCESS/WRITE (no RAM access, ram_we stays 0) and goes straight to RESP.
  - Its response has rsp_err=1 and rsp_rdata=0; latency is T+1.
  - Requests that pass the check are performed exactly as when the macro is undefined, with rsp_err=0.
- Undefined:
  - addr[1:0] is silently masked.
  - rsp*_err is tied to 0.

Test Plan:
- Load with RAM[0xBFC00010]=0xDEADBEEF: req0 load addr 0xBFC00010 → req0_ready at T; rsp0_valid at T+2 with rdata 0xDEADBEEF; ram_we never 1.
- Full store: req1 store 0xBFC00020, wdata 0x12345678, be 1111 → ram_we=1 exactly at T+1; a subsequent load returns 0x12345678.
- SB merge: RAM[0xBFC00020]=0x12345678; req0 store be 0100, wdata 0x00AB0000 → ram_we only at T+2 with ram_wd 0x12AB5678; rsp0 at T+3 with rdata 0x12345678.
- Contention: both valid continuously, RESET_PRIO=0 → grants alternate 0,1,0,1; no two grants less than 3 cycles apart; each rsp goes only to its owner.
- Reset mid-access: rst_n low during WRITE of a partial store → ram_we drops the same cycle; no rsp pulse; after release, state is IDLE and the first tie goes to requester 0.
- With DATA_ARB_ALIGN_CHECK_EN: req0 load addr 0xBFC00012 → rsp0 at T+1 with err=1, rdata 0, ram_we 0; without the macro, the word at 0xBFC00010 is returned and err=0.
